// File: rtl/rr_mux_if.sv
// rr_mux_if: channel inputs (mode/sel/in_data/in_valid/in_ready) and registered output handshake (out_*) of rr_mux_reg
interface rr_mux_if #(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 16,
  parameter int SEL_W  = 4
);
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;
  modport master (output mode, sel, in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_ch, out_valid);
  modport slave  (input  mode, sel, in_data, in_valid, out_ready,
                  output in_ready, out_data, out_ch, out_valid);
endinterface

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N:1 registered mux, direct-select or round-robin; ports clk, rst_n (async low), bus (rr_mux_if.slave)
module rr_mux_reg #(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 16,
  parameter int SEL_W  = 4
) (
  input logic     clk,
  input logic     rst_n,
  rr_mux_if.slave bus
);
  logic [SEL_W-1:0] rr_ptr, rr_g, g, out_ch_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q, rr_hit, sel_ok, grant_vld, load, xfer_in;
  int               idx;
  always_comb begin
    rr_g   = '0;
    rr_hit = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_ptr) + i >= NUM_CH) ? int'(rr_ptr) + i - NUM_CH : int'(rr_ptr) + i;
      if (!rr_hit && bus.in_valid[idx]) begin
        rr_g   = SEL_W'(idx);
        rr_hit = 1'b1;
      end
    end
  end
  assign sel_ok    = int'(bus.sel) < NUM_CH;
  assign g         = bus.mode ? rr_g : bus.sel;
  assign grant_vld = bus.mode ? |bus.in_valid : (sel_ok && bus.in_valid[bus.sel]);
  assign load      = !out_valid_q || bus.out_ready;
  assign xfer_in   = rst_n && load && grant_vld;
  always_comb begin
    bus.in_ready = '0;
    if (xfer_in) bus.in_ready[g] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr      <= '0;
    end else begin
      if (xfer_in) begin
        out_data_q  <= bus.in_data[int'(g)*WIDTH +: WIDTH];
        out_ch_q    <= g;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) out_valid_q <= 1'b0;
      if (xfer_in && bus.mode) rr_ptr <= (int'(g) == NUM_CH - 1) ? '0 : g + 1'b1;
    end
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg: directed self-checking bench for rr_mux_reg (16-channel and 12-channel instances)
module tb_rr_mux_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  always #5 clk = ~clk;
  rr_mux_if #(.WIDTH(4), .NUM_CH(16), .SEL_W(4)) ia ();
  rr_mux_if #(.WIDTH(4), .NUM_CH(12), .SEL_W(4)) ib ();
  rr_mux_reg #(.WIDTH(4), .NUM_CH(16), .SEL_W(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  rr_mux_reg #(.WIDTH(4), .NUM_CH(12), .SEL_W(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  int rr_seq [6] = '{0, 1, 15, 0, 1, 15};
  initial begin
    ia.mode = 0; ia.sel = 0; ia.in_valid = '0; ia.out_ready = 0;
    ib.mode = 0; ib.sel = 0; ib.in_valid = '0; ib.out_ready = 0;
    for (int k = 0; k < 16; k++) ia.in_data[k*4 +: 4] = 4'(15 - k);
    for (int k = 0; k < 12; k++) ib.in_data[k*4 +: 4] = 4'(15 - k);
    #7;
    ia.sel = 4'd5; ia.in_valid = 16'hFFFF; ia.out_ready = 1;
    #1;
    chk("rst_in_ready", 32'(ia.in_ready), 32'h0);
    chk("rst_valid", 32'(ia.out_valid), 32'h0);
    #14;
    rst_n = 1;
    #1;
    chk("direct_in_ready", 32'(ia.in_ready), 32'h0020);
    edge1();
    chk("direct_data", 32'(ia.out_data), 32'hA);
    chk("direct_ch", 32'(ia.out_ch), 32'd5);
    chk("direct_valid", 32'(ia.out_valid), 32'h1);
    ia.out_ready = 0; ia.sel = 4'd7;
    #1;
    chk("stall_in_ready", 32'(ia.in_ready), 32'h0);
    for (int c = 0; c < 3; c++) begin
      edge1();
      chk("stall_ch", 32'(ia.out_ch), 32'd5);
      chk("stall_data", 32'(ia.out_data), 32'hA);
      chk("stall_valid", 32'(ia.out_valid), 32'h1);
    end
    ia.out_ready = 1;
    #1;
    chk("unstall_in_ready", 32'(ia.in_ready), 32'h0080);
    edge1();
    chk("unstall_ch", 32'(ia.out_ch), 32'd7);
    chk("unstall_data", 32'(ia.out_data), 32'h8);
    chk("unstall_valid", 32'(ia.out_valid), 32'h1);
    ia.mode = 1; ia.in_valid = 16'h8003;
    for (int c = 0; c < 6; c++) begin
      edge1();
      chk("rr_wrap_ch", 32'(ia.out_ch), 32'(rr_seq[c]));
      chk("rr_wrap_valid", 32'(ia.out_valid), 32'h1);
    end
    ia.in_valid = 16'h2000;
    edge1();
    chk("rr_ch13", 32'(ia.out_ch), 32'd13);
    ia.in_valid = 16'h0008;
    #1;
    chk("rr_sparse_in_ready", 32'(ia.in_ready), 32'h0008);
    edge1();
    chk("rr_sparse_ch", 32'(ia.out_ch), 32'd3);
    chk("rr_sparse_data", 32'(ia.out_data), 32'hC);
    ia.mode = 0; ia.sel = 4'd9; ia.in_valid = 16'hFFFF;
    edge1();
    chk("mode0_ch", 32'(ia.out_ch), 32'd9);
    ia.mode = 1; ia.in_valid = 16'h0018;
    #1;
    chk("rr_ptr_kept", 32'(ia.in_ready), 32'h0010);
    edge1();
    chk("rr_ptr_ch", 32'(ia.out_ch), 32'd4);
    ia.in_valid = '0;
    edge1();
    chk("drain_valid", 32'(ia.out_valid), 32'h0);
    chk("drain_ch_hold", 32'(ia.out_ch), 32'd4);
    chk("drain_data_hold", 32'(ia.out_data), 32'hB);
    ia.mode = 0; ia.sel = 4'd2; ia.in_valid = 16'hFFFF;
    edge1();
    ia.out_ready = 0;
    chk("pre_rst_valid", 32'(ia.out_valid), 32'h1);
    chk("pre_rst_ch", 32'(ia.out_ch), 32'd2);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_valid", 32'(ia.out_valid), 32'h0);
    chk("async_rst_data", 32'(ia.out_data), 32'h0);
    chk("async_rst_ch", 32'(ia.out_ch), 32'h0);
    chk("async_rst_in_ready", 32'(ia.in_ready), 32'h0);
    #3;
    rst_n = 1;
    ia.mode = 1; ia.in_valid = 16'h8002; ia.out_ready = 1;
    ib.mode = 0; ib.sel = 4'd3; ib.in_valid = 12'hFFF; ib.out_ready = 1;
    #1;
    chk("rst_rr_ptr", 32'(ia.in_ready), 32'h0002);
    chk("b_in_ready", 32'(ib.in_ready), 32'h0008);
    edge1();
    chk("b_ch", 32'(ib.out_ch), 32'd3);
    chk("b_valid", 32'(ib.out_valid), 32'h1);
    ib.sel = 4'd13;
    #1;
    chk("b_oor_in_ready", 32'(ib.in_ready), 32'h0);
    edge1();
    chk("b_oor_valid", 32'(ib.out_valid), 32'h0);
    chk("b_oor_ch_hold", 32'(ib.out_ch), 32'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
